reg_dump_tx: RTL and testbench
==============================

Name: reg_dump_tx

Overview:
Debug read-out engine for the 32-entry register file. On a start pulse it walks register addresses 0..LAST_REG through one combinational read port. It snapshots each word and serialises it on a UART 8N1 line as an index byte followed by the data bytes, MSB byte first. It sits beside the CPU core, sharing a read port with the core's debug mux, and drives the bot's serial TX pin.

Parameters:
DATA_WIDTH, 32, register word width; must be a multiple of 8
CLKS_PER_BIT, 434, clocks per UART bit (50 MHz / 115200); minimum 2
LAST_REG, 31, highest register index dumped (0..31)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a dump; sampled only in IDLE
rd_addr  output  5  register-file read address
rd_data  input  DATA_WIDTH  register-file read data, combinational from rd_addr
tx  output  1  UART serial out, idle high, registered
busy  output  1  high from the cycle after start is accepted until the dump ends
done  output  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx=1, busy=0, done=0, rd_addr=0; all counters and shift registers cleared. Reset mid-frame aborts immediately; no partial byte is resumed.
- FSM states: IDLE, ADDR, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT.
- IDLE:
  - start=1 at edge N -> ADDR, busy=1, reg index=0, rd_addr=0.
  - start while busy is ignored. Dumps never queue.
- ADDR: one settle cycle with rd_addr=index -> LOAD.
- LOAD:
  - Capture rd_data into the word buffer. This is the only sample of this register; later writes do not affect the bytes sent.
  - Byte counter=0. The first byte sent is {3'b000, index[4:0]} -> START_BIT.
- Timing of the first frame: tx falls at edge N+2 relative to the accepted start.
- Per byte: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit holds tx for exactly CLKS_PER_BIT cycles, timed by a baud counter from 0 to CLKS_PER_BIT-1.
- Byte sequence per register: index byte, then DATA_WIDTH/8 data bytes, MSB byte first. Bytes are back-to-back with no idle gap. The next start bit follows the stop bit on the next cycle.
- NEXT, entered after the last byte of a register's stop bit:
  - If index<LAST_REG: index+1 -> ADDR. There is an inter-register gap of 2 idle-high cycles (ADDR, LOAD).
  - If index==LAST_REG: -> IDLE, busy=0, done=1 for that one cycle.
- start=1 during the done cycle is accepted at the following edge, since the block is already in IDLE.
- Register 0 reads as 0 from the register file, so its data bytes are 0x00. No special casing is needed.
- Frame length: (LAST_REG+1)*(1+DATA_WIDTH/8) bytes. Cycles from start accept to done = (LAST_REG+1)*((1+DATA_WIDTH/8)*10*CLKS_PER_BIT+2), counting edge N+1 through the done edge, +/-0 tolerance.
- rd_addr is stable for the whole ADDR, LOAD and transmit window of each register.
- Index byte width: upper 3 bits are always zero.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4 -> tx=1, busy=0, done=0, rd_addr=0 and held indefinitely with start=0.
- LAST_REG=1, reg1=0xDEADBEEF, start pulse -> byte stream 0x00,0x00,0x00,0x00,0x00,0x01,0xDE,0xAD,0xBE,0xEF. Byte 0x01 appears on the line as bits 0,1,0,0,0,0,0,0,0,1, each held 4 cycles. done asserts exactly 2*(5*40+2)=404 cycles after the accept edge.
- Snapshot: during transmission of reg1, the core writes reg1=0x12345678 -> the line still carries DE AD BE EF. A second dump then carries 12 34 56 78.
- start pulses while busy=1, mid byte and in ADDR -> no restart and no change to the stream. Exactly one done pulse.
- Async reset asserted mid DATA_BITS of reg 17 (LAST_REG=31) -> tx=1 and busy=0 immediately without a clock edge. After release and a new start, the dump restarts at index 0x00.
- start held high across done -> a second dump begins. tx falls 2 edges after the done cycle, and the index byte is 0x00 again.

Source files
------------

// File: rtl/reg_dump_tx_if.sv
// Signal bundle between the register dump engine and its surroundings:
// start request, register-file read port, serial line and status flags.
interface reg_dump_tx_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [4:0]            rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  tx;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, rd_data,
    output rd_addr, tx, busy, done
  );

  modport slave (
    output start, rd_data,
    input  rd_addr, tx, busy, done
  );
endinterface

// File: rtl/reg_dump_tx.sv
// Debug read-out engine: walks registers 0..LAST_REG and sends each as an
// index byte plus its data bytes (MSB byte first) on a UART 8N1 line.
module reg_dump_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 434,
  parameter int LAST_REG     = 31
) (
  input  logic          clk,
  input  logic          reset,
  reg_dump_tx_if.master bus
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = $clog2(BYTES + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES);
  localparam logic [4:0]        LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    IDLE, ADDR, LOAD, START_BIT, DATA_BITS, STOP_BIT, NEXT
  } state_t;

  state_t                state, state_next, after_reg;
  logic [4:0]            index, index_d;
  logic [DATA_WIDTH-1:0] word, word_d;
  logic [7:0]            shreg, shreg_d;
  logic [BYTE_W-1:0]     byte_cnt, byte_cnt_d;
  logic [2:0]            bit_cnt, bit_cnt_d;
  logic [BAUD_W-1:0]     baud_cnt, baud_d;
  logic                  tx_q, busy_q, done_q;
  logic                  tx_d, busy_d, done_d;
  logic                  baud_end;

  assign baud_end    = (baud_cnt == BAUD_LAST);
  assign after_reg   = (index == LAST_IDX) ? IDLE : ADDR;
  assign bus.rd_addr = index;
  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      index    <= '0;
      word     <= '0;
      shreg    <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      index    <= index_d;
      word     <= word_d;
      shreg    <= shreg_d;
      byte_cnt <= byte_cnt_d;
      bit_cnt  <= bit_cnt_d;
      baud_cnt <= baud_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The NEXT decision is folded into the final stop-bit cycle so the
  // inter-register gap stays at two cycles; NEXT itself is only a fallback.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (bus.start) state_next = ADDR;
      ADDR:      state_next = LOAD;
      LOAD:      state_next = START_BIT;
      START_BIT: if (baud_end) state_next = DATA_BITS;
      DATA_BITS: if (baud_end && bit_cnt == 3'd7) state_next = STOP_BIT;
      STOP_BIT:  if (baud_end) state_next = (byte_cnt == BYTE_LAST) ? after_reg : START_BIT;
      NEXT:      state_next = after_reg;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    index_d    = index;
    word_d     = word;
    shreg_d    = shreg;
    byte_cnt_d = byte_cnt;
    bit_cnt_d  = bit_cnt;
    baud_d     = baud_end ? '0 : baud_cnt + 1'b1;
    case (state)
      IDLE: begin
        baud_d = '0;
        if (bus.start) index_d = '0;
      end
      ADDR: baud_d = '0;
      LOAD: begin
        baud_d     = '0;
        word_d     = bus.rd_data;
        shreg_d    = {3'b000, index};
        byte_cnt_d = '0;
        bit_cnt_d  = '0;
      end
      DATA_BITS: begin
        if (baud_end) begin
          shreg_d   = {1'b0, shreg[7:1]};
          bit_cnt_d = bit_cnt + 1'b1;
        end
      end
      STOP_BIT: begin
        if (baud_end) begin
          if (byte_cnt == BYTE_LAST) begin
            index_d = (index == LAST_IDX) ? '0 : index + 1'b1;
          end else begin
            shreg_d    = word[DATA_WIDTH-1 -: 8];
            word_d     = word << 8;
            byte_cnt_d = byte_cnt + 1'b1;
          end
        end
      end
      NEXT: index_d = (index == LAST_IDX) ? '0 : index + 1'b1;
      default: ;
    endcase

    // tx is registered, so it follows the state being entered.
    tx_d = 1'b1;
    if (state_next == START_BIT)      tx_d = 1'b0;
    else if (state_next == DATA_BITS) tx_d = shreg_d[0];
    busy_d = (state_next != IDLE);
    done_d = (state_next == IDLE) && (state == STOP_BIT || state == NEXT);
  end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Self-checking bench for reg_dump_tx: table vectors, a line-level UART
// reference model with random register contents, and reset/start corner cases.
module tb_reg_dump_tx;

  localparam int DW          = 32;
  localparam int CPB         = 4;
  localparam int BPR         = 1 + DW / 8;
  localparam int CYC_PER_REG = BPR * 10 * CPB + 2;

  typedef struct packed {
    logic [31:0] reg1;
    logic [1:0]  poke;
    logic [15:0] write_at;
    logic [31:0] write_val;
    logic [79:0] stream;
    logic [15:0] cycles;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] regs [32];
  logic        sel_b = 1'b0;
  logic        tx_s, busy_s, done_s;
  logic [4:0]  addr_s;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_bytes [$];
  logic        exp_line [$];
  vec_t        vecs [4];

  reg_dump_tx_if #(.DATA_WIDTH(DW)) bus_a ();
  reg_dump_tx_if #(.DATA_WIDTH(DW)) bus_b ();

  reg_dump_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .LAST_REG(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.master)
  );
  reg_dump_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .LAST_REG(31)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.master)
  );

  // Register file read port: combinational, register 0 hard-wired to zero.
  assign bus_a.rd_data = (bus_a.rd_addr == 5'd0) ? '0 : regs[bus_a.rd_addr];
  assign bus_b.rd_data = (bus_b.rd_addr == 5'd0) ? '0 : regs[bus_b.rd_addr];

  assign tx_s   = sel_b ? bus_b.tx      : bus_a.tx;
  assign busy_s = sel_b ? bus_b.busy    : bus_a.busy;
  assign done_s = sel_b ? bus_b.done    : bus_a.done;
  assign addr_s = sel_b ? bus_b.rd_addr : bus_a.rd_addr;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic apply_stimulus(input logic v);
    if (sel_b) bus_b.start = v;
    else       bus_a.start = v;
  endtask

  // Expected line: two idle-high cycles per register, then 10 bits per byte.
  task automatic line_from_bytes();
    logic [7:0] b;
    logic       v;
    exp_line.delete();
    for (int i = 0; i < exp_bytes.size(); i++) begin
      b = exp_bytes[i];
      if (i % BPR == 0) begin
        exp_line.push_back(1'b1);
        exp_line.push_back(1'b1);
      end
      for (int n = 0; n < 10; n++) begin
        v = (n == 0) ? 1'b0 : (n == 9) ? 1'b1 : b[n-1];
        repeat (CPB) exp_line.push_back(v);
      end
    end
  endtask

  task automatic model_bytes(input int last_reg);
    logic [DW-1:0] w;
    exp_bytes.delete();
    for (int r = 0; r <= last_reg; r++) begin
      w = (r == 0) ? '0 : regs[r];
      exp_bytes.push_back(8'(r));
      for (int j = 0; j < DW / 8; j++) exp_bytes.push_back(w[DW-1-8*j -: 8]);
    end
    line_from_bytes();
  endtask

  task automatic bytes_from_stream(input logic [79:0] s);
    exp_bytes.delete();
    for (int i = 0; i < 10; i++) exp_bytes.push_back(s[79-8*i -: 8]);
    line_from_bytes();
  endtask

  // Called one sample after the accepting edge; ends on the done sample.
  task automatic check_dump(input string tag, input int cycles, input int poke_mode,
                            input int write_at, input int write_idx, input logic [31:0] write_val);
    int   line_err = 0;
    int   busy_err = 0;
    int   done_err = 0;
    int   first_k = -1;
    logic want;
    for (int k = 0; k < cycles; k++) begin
      want = (k < exp_line.size()) ? exp_line[k] : 1'b1;
      if (tx_s !== want) begin
        line_err++;
        if (first_k < 0) first_k = k;
      end
      if (busy_s !== 1'b1) busy_err++;
      if (done_s !== 1'b0) done_err++;
      if (k == write_at) regs[write_idx] = write_val;
      if (poke_mode == 2)      apply_stimulus(1'b1);
      else if (poke_mode == 1) apply_stimulus(k == 0 || k == 20 || k == 202 || k == 300);
      else                     apply_stimulus(1'b0);
      tick();
    end
    if (poke_mode != 2) apply_stimulus(1'b0);
    check_output($sformatf("%s tx line bad cycles (first at %0d)", tag, first_k), line_err, 0);
    check_output({tag, " busy low cycles"}, busy_err, 0);
    check_output({tag, " early done cycles"}, done_err, 0);
    check_output({tag, " done at end"}, 32'(done_s), 1);
    check_output({tag, " busy at end"}, 32'(busy_s), 0);
    check_output({tag, " tx at end"}, 32'(tx_s), 1);
  endtask

  task automatic check_done_clear(input string tag);
    tick();
    check_output({tag, " done one cycle"}, 32'(done_s), 0);
    check_output({tag, " idle busy"}, 32'(busy_s), 0);
  endtask

  initial begin
    int errs [4];
    int r;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = '0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;

    vecs[0] = '{32'hDEADBEEF, 2'd0, 16'hFFFF, 32'h0,
                80'h00_00000000_01_DEADBEEF, 16'd404};
    vecs[1] = '{32'hDEADBEEF, 2'd0, 16'd250, 32'h12345678,
                80'h00_00000000_01_DEADBEEF, 16'd404};
    vecs[2] = '{32'h12345678, 2'd0, 16'hFFFF, 32'h0,
                80'h00_00000000_01_12345678, 16'd404};
    vecs[3] = '{32'h00FF8001, 2'd1, 16'hFFFF, 32'h0,
                80'h00_00000000_01_00FF8001, 16'd404};

    repeat (3) tick();
    check_output("reset tx", 32'(bus_a.tx), 1);
    check_output("reset busy", 32'(bus_a.busy), 0);
    check_output("reset done", 32'(bus_a.done), 0);
    check_output("reset rd_addr", 32'(bus_a.rd_addr), 0);

    reset = 1'b1;
    errs = '{0, 0, 0, 0};
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus_a.tx !== 1'b1 || bus_b.tx !== 1'b1) errs[0]++;
      if (bus_a.busy !== 1'b0 || bus_b.busy !== 1'b0) errs[1]++;
      if (bus_a.done !== 1'b0 || bus_b.done !== 1'b0) errs[2]++;
      if (bus_a.rd_addr !== 5'd0 || bus_b.rd_addr !== 5'd0) errs[3]++;
    end
    check_output("idle hold tx", errs[0], 0);
    check_output("idle hold busy", errs[1], 0);
    check_output("idle hold done", errs[2], 0);
    check_output("idle hold rd_addr", errs[3], 0);

    sel_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      regs[1] = vecs[i].reg1;
      bytes_from_stream(vecs[i].stream);
      apply_stimulus(1'b1);
      tick();
      check_dump($sformatf("vec%0d", i), int'(vecs[i].cycles), int'(vecs[i].poke),
                 int'(vecs[i].write_at), 1, vecs[i].write_val);
      check_done_clear($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 3; i++) begin
      regs[1] = $urandom;
      repeat ($urandom_range(0, 5)) tick();
      model_bytes(1);
      apply_stimulus(1'b1);
      tick();
      check_dump($sformatf("rand%0d", i), 2 * CYC_PER_REG, 0,
                 int'($urandom_range(CYC_PER_REG + 2, 2 * CYC_PER_REG - 1)), 1, $urandom);
      check_done_clear($sformatf("rand%0d", i));
    end

    // start held high across done: second dump must follow immediately
    regs[1] = $urandom;
    model_bytes(1);
    apply_stimulus(1'b1);
    tick();
    check_dump("hold1", 2 * CYC_PER_REG, 2, -1, 1, 32'h0);
    tick();
    check_dump("hold2", 2 * CYC_PER_REG, 0, -1, 1, 32'h0);
    check_done_clear("hold2");

    // async reset in the middle of register 17's index byte
    sel_b = 1'b1;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    model_bytes(31);
    apply_stimulus(1'b1);
    tick();
    apply_stimulus(1'b0);
    for (int k = 0; k < 17 * CYC_PER_REG + 12; k++) tick();
    check_output("mid reg17 rd_addr", 32'(addr_s), 17);
    check_output("mid reg17 tx", 32'(tx_s), 32'(exp_line[17 * CYC_PER_REG + 12]));
    #2 reset = 1'b0;
    #1;
    check_output("async reset tx", 32'(tx_s), 1);
    check_output("async reset busy", 32'(busy_s), 0);
    check_output("async reset done", 32'(done_s), 0);
    check_output("async reset rd_addr", 32'(addr_s), 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    model_bytes(31);
    r = int'($urandom_range(1, 31));
    apply_stimulus(1'b1);
    tick();
    check_dump("full31", 32 * CYC_PER_REG, 0,
               r * CYC_PER_REG + int'($urandom_range(3, CYC_PER_REG - 1)), r, $urandom);
    check_done_clear("full31");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
